mp5_addr_map: RTL and testbench
===============================

Name: mp5_addr_map

Overview:
- Phantom-slot address map paired with each mp5 stage.
- Consumes the stage's phantom-push report, which carries a packet id and the FIFO slot that was reserved for the phantom.
- When the real packet with the same id later reaches that stage, drives the stage's insert handshake (insert_in, addr_in, fifo_id_in) so the real packet overwrites its reserved slot.
- Sits beside each mp5 stage, between the stage's push outputs and its insert inputs.

Parameters:
- NUM_PIPELINES, 4, number of pipelines; sets the fifo_id width, $clog2(NUM_PIPELINES).
- FIFO_SIZE, 8, per-FIFO depth; sets the slot address width, $clog2(FIFO_SIZE).
- MAP_DEPTH, 8, number of map entries; power of 2, at least 2.
- TIMEOUT, 1024, cycles before an unclaimed entry is expired; 0 disables expiry.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rec_valid  in  1  phantom push recorded by the stage this cycle.
- rec_id  in  16  phantom packet id.
- rec_fifo_id  in  $clog2(NUM_PIPELINES)  FIFO that holds the phantom.
- rec_addr  in  $clog2(FIFO_SIZE)  slot address of the phantom.
- lkp_valid  in  1  real packet arriving; request its slot.
- lkp_id  in  16  real packet id.
- insert_out  out  1  one-cycle pulse; drives the stage insert_in.
- insert_addr  out  $clog2(FIFO_SIZE)  drives the stage addr_in.
- insert_fifo_id  out  $clog2(NUM_PIPELINES)  drives the stage fifo_id_in for the insert.
- miss_out  out  1  one-cycle pulse; lookup found no entry.
- expire_out  out  1  one-cycle pulse; an entry timed out.
- overflow  out  1  sticky flag; a record was dropped because the map was full.
- occupancy  out  $clog2(MAP_DEPTH)+1  number of valid entries.

Behaviour:
- Entry contents: valid, id[15:0], fifo_id, addr, stamp[15:0].
- Free-running 16-bit counter `now` increments every cycle. Entry age is now minus stamp, modulo 2^16. TIMEOUT must be below 2^15.
- Reset: all entries invalid; now=0; scan pointer=0. All outputs are 0.
- Reset mid-operation: every pending record, lookup and pulse is discarded on the next clock edge; no insert is issued afterwards.
- Record (rec_valid=1), applied on the clock edge:
  - If a valid entry already has the same id, overwrite its fifo_id, addr and stamp.
  - Otherwise allocate the lowest-index free entry.
  - If no entry is free, drop the record and set overflow to 1. Overflow stays set until rst.
- Lookup (lkp_valid=1): fully associative match on id across valid entries. Outputs are registered, so the response appears exactly 1 cycle after lkp_valid.
  - Hit: insert_out=1 with the entry's addr and fifo_id. The entry is invalidated on that same edge.
  - No hit: miss_out=1. insert_addr and insert_fifo_id hold their previous values.
- Record and lookup in the same cycle with equal ids: bypass.
  - The lookup hits using rec_addr and rec_fifo_id.
  - Nothing is stored, and overflow is not set even if the map is full.
  - If a stale entry with that id exists, it is invalidated.
- Record and lookup in the same cycle with different ids: both proceed. An entry freed by the lookup is not reusable by the record until the next cycle.
- Expiry (TIMEOUT≠0):
  - The scan pointer visits one entry per cycle, wrapping at MAP_DEPTH-1 back to 0.
  - If the visited entry is valid and its age ≥ TIMEOUT, it is invalidated and expire_out pulses on the next cycle.
  - Priority when the scan conflicts on the same entry in the same cycle: lookup hit beats record update, which beats expiry. A hit or update suppresses the expiry.
  - An entry is therefore expired at most TIMEOUT+MAP_DEPTH-1 cycles after its last stamp.
- Occupancy is registered and always equals the count of valid entries after the edge. Per cycle it changes by +1, 0, -1 or -2.
- insert_out, miss_out and expire_out are each high for exactly one cycle per event. insert_out and miss_out are mutually exclusive.

Decomposition:
- Shared package mp5_pkg holds:
  - NUM_PIPELINES, NUM_STAGES and FIFO_SIZE;
  - the Packet, FIFO_Entry and Entry typedefs;
  - a new Map_Entry typedef (valid, id, fifo_id, addr, stamp).
- One sub-module, mp5_first_free: a parameterised lowest-index priority encoder over the valid vector. It outputs the free index and a found flag, and also serves the stage's min-timestamp tree.

Test Plan:
- Record id=0x0012, fifo 2, addr 5; 3 cycles later lookup id=0x0012 → insert_out=1, insert_addr=5, insert_fifo_id=2 one cycle after the lookup; occupancy goes 1→0.
- Lookup id=0x0099 with an empty map → miss_out=1 one cycle later; insert_out=0; occupancy=0.
- Fill MAP_DEPTH=8 with ids 1..8, then record id=9 → occupancy=8, overflow=1; lookup id=9 → miss.
- Same-cycle record and lookup of id=0x0040, addr 3, fifo 1 → insert_out=1, insert_addr=3, insert_fifo_id=1; occupancy stays 0.
- TIMEOUT=16, record id=7, no lookup → expire_out pulses once between cycle 16 and cycle 24 after the record; a later lookup of id 7 → miss.
- Record id=5 addr 1, then record id=5 addr 6, then lookup id=5 → insert_addr=6; occupancy peaks at 1. Assert rst while a lookup is pending → no insert_out afterwards; all outputs 0.

Source files
------------

// File: rtl/mp5_pkg.sv
// mp5_pkg: types and sizes shared by the mp5 stage and its helpers.
//   NUM_PIPELINES / NUM_STAGES / FIFO_SIZE : default pipeline geometry.
//   Packet, FIFO_Entry, Entry               : stage data types.
//   Map_Entry                               : one phantom-slot map entry.
package mp5_pkg;

    localparam int NUM_PIPELINES = 4;
    localparam int NUM_STAGES    = 4;
    localparam int FIFO_SIZE     = 8;

    localparam int MP5_FID_W  = $clog2(NUM_PIPELINES);
    localparam int MP5_ADDR_W = $clog2(FIFO_SIZE);

    typedef struct packed {
        logic [15:0]           id;
        logic [MP5_FID_W-1:0]  pipe;
        logic [31:0]           data;
    } Packet;

    typedef struct packed {
        logic  valid;
        logic  phantom;
        Packet pkt;
    } FIFO_Entry;

    typedef struct packed {
        logic                  valid;
        logic [15:0]           stamp;
        logic [MP5_FID_W-1:0]  fifo_id;
        logic [MP5_ADDR_W-1:0] addr;
    } Entry;

    // Reserved-slot record: where the phantom for packet `id` lives.
    typedef struct packed {
        logic                  valid;
        logic [15:0]           id;
        logic [MP5_FID_W-1:0]  fifo_id;
        logic [MP5_ADDR_W-1:0] addr;
        logic [15:0]           stamp;
    } Map_Entry;

endpackage

// File: rtl/mp5_addr_map_if.sv
// mp5_addr_map_if: record/lookup inputs and insert/status outputs of the
// phantom-slot address map.
//   master : the stage side (drives rec_*, lkp_*).
//   slave  : the map itself.
interface mp5_addr_map_if #(
    parameter int FID_W  = 2,
    parameter int ADDR_W = 3,
    parameter int OCC_W  = 4
);
    logic              rec_valid;
    logic [15:0]       rec_id;
    logic [FID_W-1:0]  rec_fifo_id;
    logic [ADDR_W-1:0] rec_addr;
    logic              lkp_valid;
    logic [15:0]       lkp_id;
    logic              insert_out;
    logic [ADDR_W-1:0] insert_addr;
    logic [FID_W-1:0]  insert_fifo_id;
    logic              miss_out;
    logic              expire_out;
    logic              overflow;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output rec_valid, rec_id, rec_fifo_id, rec_addr, lkp_valid, lkp_id,
        input  insert_out, insert_addr, insert_fifo_id, miss_out, expire_out,
               overflow, occupancy
    );

    modport slave (
        input  rec_valid, rec_id, rec_fifo_id, rec_addr, lkp_valid, lkp_id,
        output insert_out, insert_addr, insert_fifo_id, miss_out, expire_out,
               overflow, occupancy
    );
endinterface

// File: rtl/mp5_first_free.sv
// mp5_first_free: lowest-index priority encoder over a valid vector.
//   valid_i : occupancy bits; a 0 bit is a candidate.
//   idx_o   : lowest index whose bit is 0.
//   found_o : at least one bit is 0.
// Feeding an inverted match vector turns it into a lowest-set-bit finder.
module mp5_first_free #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Walk downward so the last hit written is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                idx_o   = IW'(i);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mp5_addr_map.sv
// mp5_addr_map: phantom-slot address map beside one mp5 stage.
//   clk, rst : clock, synchronous active-high reset.
//   m        : slave modport; rec_* records a phantom's reserved slot,
//              lkp_* asks for it when the real packet arrives. Responses
//              (insert_*/miss_out) are registered, one cycle after lkp_valid.
//              expire_out pulses when a stale entry is aged out; overflow is
//              sticky; occupancy counts valid entries.
module mp5_addr_map #(
    parameter int NUM_PIPELINES = mp5_pkg::NUM_PIPELINES,
    parameter int FIFO_SIZE     = mp5_pkg::FIFO_SIZE,
    parameter int MAP_DEPTH     = 8,
    parameter int TIMEOUT       = 1024
) (
    input  logic          clk,
    input  logic          rst,
    mp5_addr_map_if.slave m
);
    import mp5_pkg::*;

    localparam int IDX_W  = $clog2(MAP_DEPTH);
    localparam int OCC_W  = IDX_W + 1;
    localparam int FID_W  = $clog2(NUM_PIPELINES);
    localparam int ADDR_W = $clog2(FIFO_SIZE);

    Map_Entry          ent_q [MAP_DEPTH];
    Map_Entry          ent_d [MAP_DEPTH];
    logic [15:0]       now_q;
    logic [IDX_W-1:0]  scan_q, scan_d;
    logic              ins_q, ins_d, miss_q, miss_d, exp_q, exp_d, ovf_q, ovf_d;
    logic [ADDR_W-1:0] ins_addr_q, ins_addr_d;
    logic [FID_W-1:0]  ins_fid_q, ins_fid_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [MAP_DEPTH-1:0] valid_vec, rec_nomatch, lkp_nomatch, busy;
    logic [IDX_W-1:0]     free_idx, upd_idx, hit_idx;
    logic                 free_found, upd_found, hit_found, bypass;
    logic [15:0]          age;

    always_comb begin
        for (int i = 0; i < MAP_DEPTH; i++) begin
            valid_vec[i]   = ent_q[i].valid;
            rec_nomatch[i] = !(ent_q[i].valid && ent_q[i].id == m.rec_id);
            lkp_nomatch[i] = !(ent_q[i].valid && ent_q[i].id == m.lkp_id);
        end
    end

    mp5_first_free #(.N(MAP_DEPTH), .IW(IDX_W)) u_free (
        .valid_i(valid_vec),   .idx_o(free_idx), .found_o(free_found));
    mp5_first_free #(.N(MAP_DEPTH), .IW(IDX_W)) u_upd (
        .valid_i(rec_nomatch), .idx_o(upd_idx),  .found_o(upd_found));
    mp5_first_free #(.N(MAP_DEPTH), .IW(IDX_W)) u_hit (
        .valid_i(lkp_nomatch), .idx_o(hit_idx),  .found_o(hit_found));

    assign bypass = m.rec_valid && m.lkp_valid && (m.rec_id == m.lkp_id);
    assign age    = now_q - ent_q[scan_q].stamp;
    assign scan_d = (scan_q == IDX_W'(MAP_DEPTH - 1)) ? '0 : scan_q + 1'b1;

    always_comb begin
        for (int i = 0; i < MAP_DEPTH; i++) ent_d[i] = ent_q[i];
        ins_d      = 1'b0;
        miss_d     = 1'b0;
        exp_d      = 1'b0;
        ovf_d      = ovf_q;
        ins_addr_d = ins_addr_q;
        ins_fid_d  = ins_fid_q;
        busy       = '0;
        occ_d      = '0;

        if (m.lkp_valid) begin
            if (bypass) begin
                // Real packet caught up with its own phantom report; any
                // older entry for this id is stale.
                ins_d      = 1'b1;
                ins_addr_d = m.rec_addr;
                ins_fid_d  = m.rec_fifo_id;
                if (hit_found) begin
                    ent_d[hit_idx].valid = 1'b0;
                    busy[hit_idx]        = 1'b1;
                end
            end else if (hit_found) begin
                ins_d                = 1'b1;
                ins_addr_d           = ent_q[hit_idx].addr;
                ins_fid_d            = ent_q[hit_idx].fifo_id;
                ent_d[hit_idx].valid = 1'b0;
                busy[hit_idx]        = 1'b1;
            end else begin
                miss_d = 1'b1;
            end
        end

        if (m.rec_valid && !bypass) begin
            if (upd_found) begin
                ent_d[upd_idx].fifo_id = m.rec_fifo_id;
                ent_d[upd_idx].addr    = m.rec_addr;
                ent_d[upd_idx].stamp   = now_q;
                busy[upd_idx]          = 1'b1;
            end else if (free_found) begin
                // free_idx comes from ent_q, so a slot freed by this cycle's
                // lookup is not reused until next cycle.
                ent_d[free_idx] = '{valid: 1'b1, id: m.rec_id,
                                    fifo_id: m.rec_fifo_id, addr: m.rec_addr,
                                    stamp: now_q};
            end else begin
                ovf_d = 1'b1;
            end
        end

        // Expiry only touches valid entries, so it never collides with an
        // allocation; hit/update on the scanned entry suppresses it.
        if (TIMEOUT != 0 && ent_q[scan_q].valid && !busy[scan_q] &&
            age >= 16'(TIMEOUT)) begin
            ent_d[scan_q].valid = 1'b0;
            exp_d               = 1'b1;
        end

        for (int i = 0; i < MAP_DEPTH; i++) occ_d = occ_d + OCC_W'(ent_d[i].valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAP_DEPTH; i++) ent_q[i] <= '0;
            now_q      <= '0;
            scan_q     <= '0;
            ins_q      <= 1'b0;
            miss_q     <= 1'b0;
            exp_q      <= 1'b0;
            ovf_q      <= 1'b0;
            ins_addr_q <= '0;
            ins_fid_q  <= '0;
            occ_q      <= '0;
        end else begin
            for (int i = 0; i < MAP_DEPTH; i++) ent_q[i] <= ent_d[i];
            now_q      <= now_q + 16'd1;
            scan_q     <= scan_d;
            ins_q      <= ins_d;
            miss_q     <= miss_d;
            exp_q      <= exp_d;
            ovf_q      <= ovf_d;
            ins_addr_q <= ins_addr_d;
            ins_fid_q  <= ins_fid_d;
            occ_q      <= occ_d;
        end
    end

    assign m.insert_out     = ins_q;
    assign m.insert_addr    = ins_addr_q;
    assign m.insert_fifo_id = ins_fid_q;
    assign m.miss_out       = miss_q;
    assign m.expire_out     = exp_q;
    assign m.overflow       = ovf_q;
    assign m.occupancy      = occ_q;
endmodule

// File: tb/tb_mp5_addr_map.sv
module tb_mp5_addr_map;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_exp;
    int   exp_at;

    always #5 clk = ~clk;

    mp5_addr_map_if #(.FID_W(2), .ADDR_W(3), .OCC_W(4)) bus ();

    mp5_addr_map #(.NUM_PIPELINES(4), .FIFO_SIZE(8), .MAP_DEPTH(8), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .m  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rec_valid = 1'b0;
        bus.lkp_valid = 1'b0;
    endtask

    task automatic rec(input logic [15:0] id, input logic [1:0] fid, input logic [2:0] addr);
        bus.rec_valid   = 1'b1;
        bus.rec_id      = id;
        bus.rec_fifo_id = fid;
        bus.rec_addr    = addr;
    endtask

    task automatic lkp(input logic [15:0] id);
        bus.lkp_valid = 1'b1;
        bus.lkp_id    = id;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.rec_valid = 1'b0; bus.rec_id = '0; bus.rec_fifo_id = '0; bus.rec_addr = '0;
        bus.lkp_valid = 1'b0; bus.lkp_id = '0;
        step(); step();
        rst = 1'b0;
        check("rst_insert", bus.insert_out, 0);
        check("rst_miss",   bus.miss_out, 0);
        check("rst_expire", bus.expire_out, 0);
        check("rst_ovf",    bus.overflow, 0);
        check("rst_occ",    bus.occupancy, 0);
        check("rst_addr",   bus.insert_addr, 0);

        // Basic record then lookup
        rec(16'h0012, 2'd2, 3'd5); step(); idle();
        check("t1_occ1", bus.occupancy, 1);
        step(); step();
        lkp(16'h0012); step(); idle();
        check("t1_ins",  bus.insert_out, 1);
        check("t1_addr", bus.insert_addr, 5);
        check("t1_fid",  bus.insert_fifo_id, 2);
        check("t1_miss", bus.miss_out, 0);
        check("t1_occ0", bus.occupancy, 0);
        step();
        check("t1_pulse", bus.insert_out, 0);

        // Miss on empty map; insert address holds
        lkp(16'h0099); step(); idle();
        check("t2_miss", bus.miss_out, 1);
        check("t2_ins",  bus.insert_out, 0);
        check("t2_hold", bus.insert_addr, 5);
        check("t2_occ",  bus.occupancy, 0);
        step();
        check("t2_pulse", bus.miss_out, 0);

        // Fill, overflow, freed slot not reused same cycle
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            rec(16'(i), 2'(i % 4), 3'(i % 8)); step();
        end
        idle();
        check("t3_full", bus.occupancy, 8);
        check("t3_noovf", bus.overflow, 0);
        rec(16'd9, 2'd1, 3'd1); step(); idle();
        check("t3_occ8", bus.occupancy, 8);
        check("t3_ovf", bus.overflow, 1);
        lkp(16'd9); step(); idle();
        check("t3_miss9", bus.miss_out, 1);
        rec(16'd20, 2'd0, 3'd4); lkp(16'd3); step(); idle();
        check("t3_ins3",  bus.insert_out, 1);
        check("t3_addr3", bus.insert_addr, 3);
        check("t3_occ7",  bus.occupancy, 7);
        rec(16'd20, 2'd0, 3'd4); step(); idle();
        check("t3_reuse", bus.occupancy, 8);
        lkp(16'd20); step(); idle();
        check("t3_hit20",  bus.insert_out, 1);
        check("t3_addr20", bus.insert_addr, 4);
        check("t3_ovfsticky", bus.overflow, 1);

        // Same-cycle bypass
        do_reset();
        check("t4_rstovf", bus.overflow, 0);
        rec(16'h0040, 2'd1, 3'd3); lkp(16'h0040); step(); idle();
        check("t4_ins",  bus.insert_out, 1);
        check("t4_addr", bus.insert_addr, 3);
        check("t4_fid",  bus.insert_fifo_id, 1);
        check("t4_occ",  bus.occupancy, 0);

        // Expiry with TIMEOUT=16
        do_reset();
        rec(16'd7, 2'd0, 3'd2); step(); idle();
        n_exp = 0; exp_at = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.expire_out) begin
                n_exp++;
                if (exp_at == 0) exp_at = i;
            end
        end
        check("t5_once", n_exp, 1);
        check("t5_window", (exp_at >= 16 && exp_at <= 24) ? 1 : 0, 1);
        check("t5_occ", bus.occupancy, 0);
        lkp(16'd7); step(); idle();
        check("t5_miss", bus.miss_out, 1);

        // Update in place
        do_reset();
        rec(16'd5, 2'd0, 3'd1); step(); idle();
        check("t6_occa", bus.occupancy, 1);
        rec(16'd5, 2'd3, 3'd6); step(); idle();
        check("t6_occb", bus.occupancy, 1);
        lkp(16'd5); step(); idle();
        check("t6_addr", bus.insert_addr, 6);
        check("t6_fid",  bus.insert_fifo_id, 3);
        check("t6_occ0", bus.occupancy, 0);

        // Reset with lookup pending
        rec(16'h0033, 2'd2, 3'd7); step(); idle();
        lkp(16'h0033); rst = 1'b1; step(); rst = 1'b0; idle();
        check("t7_ins",  bus.insert_out, 0);
        check("t7_miss", bus.miss_out, 0);
        check("t7_addr", bus.insert_addr, 0);
        check("t7_fid",  bus.insert_fifo_id, 0);
        check("t7_occ",  bus.occupancy, 0);
        step(); step();
        check("t7_after", bus.insert_out, 0);
        check("t7_exp",   bus.expire_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
